// File: rtl/clock_pkg.sv
// Shared clock-domain constants and the speed-to-stage mapping
// used by the enable generator.
package clock_pkg;

  localparam int unsigned SPEED_SLOW = 0;

  // Speeds beyond the fastest stage saturate onto stage 0.
  function automatic int unsigned speed_sel(
    input int unsigned s,
    input int unsigned stages
  );
    if (s > stages - 1) return 0;
    return stages - 1 - s;
  endfunction

endpackage

// File: rtl/clock_enable_gen.sv
// Falling-edge divider producing per-stage pe/ne enables and a
// speed-selectable, hold-aware CPU enable pair.
module clock_enable_gen
  import clock_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int SW     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [SW-1:0]     speed_req,
  input  logic              hold,
  output logic [STAGES-1:0] pe,
  output logic [STAGES-1:0] ne,
  output logic              cpu_pe,
  output logic              cpu_ne,
  output logic [SW-1:0]     speed,
  output logic              sync
);

  localparam int CW   = STAGES + 1;
  localparam int SELW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [CW-1:0]     r_cnt;
  logic              r_blocked;
  logic [STAGES-1:0] w_pe;
  logic [STAGES-1:0] w_ne;
  logic [SELW-1:0]   w_sel;
  logic              w_cpe;
  logic              w_cne;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign w_ne[k] = (r_cnt[k+1:0] == '0);
    assign w_pe[k] = r_cnt[k+1] && (r_cnt[k:0] == '0);
  end

  assign w_sel = SELW'(speed_sel(32'(speed), STAGES));
  assign w_cpe = w_pe[w_sel];
  assign w_cne = w_ne[w_sel];

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= CW'(1);
      r_blocked <= 1'b0;
      speed     <= SW'(SPEED_SLOW);
      pe        <= '0;
      ne        <= '0;
      cpu_pe    <= 1'b0;
      cpu_ne    <= 1'b0;
      sync      <= 1'b0;
    end else if (!run) begin
      pe     <= '0;
      ne     <= '0;
      cpu_pe <= 1'b0;
      cpu_ne <= 1'b0;
      sync   <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      pe     <= w_pe;
      ne     <= w_ne;
      sync   <= w_ne[STAGES-1];
      cpu_pe <= w_cpe & ~hold;
      cpu_ne <= w_cne & ~r_blocked;
      // A swallowed pe also swallows its matching ne.
      if (w_cpe && hold) begin
        r_blocked <= 1'b1;
      end else if (w_cne) begin
        r_blocked <= 1'b0;
      end
      // Commit only at the frame boundary, where every ne fires.
      if (w_ne[STAGES-1]) begin
        speed <= speed_req;
      end
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboarded bench for clock_enable_gen at STAGES=3, SW=2.
// A behavioural model predicts every registered output per edge.
module tb_clock_enable_gen;

  localparam int STAGES = 3;
  localparam int SW     = 2;
  localparam int CMOD   = 1 << (STAGES + 1);

  typedef struct packed {
    logic [STAGES-1:0] pe;
    logic [STAGES-1:0] ne;
    logic              cpe;
    logic              cne;
    logic [SW-1:0]     spd;
    logic              sync;
  } exp_t;

  logic              clock = 1'b1;
  logic              reset = 1'b1;
  logic              run = 1'b0;
  logic [SW-1:0]     speed_req = '0;
  logic              hold = 1'b0;
  logic [STAGES-1:0] pe;
  logic [STAGES-1:0] ne;
  logic              cpu_pe;
  logic              cpu_ne;
  logic [SW-1:0]     speed;
  logic              sync;

  exp_t  q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    m_cnt = 1;
  int    m_speed = 0;
  logic  m_blocked = 1'b0;
  string tname = "none";

  clock_enable_gen #(.STAGES(STAGES), .SW(SW)) dut (
    .clock(clock), .reset(reset), .run(run),
    .speed_req(speed_req), .hold(hold),
    .pe(pe), .ne(ne), .cpu_pe(cpu_pe), .cpu_ne(cpu_ne),
    .speed(speed), .sync(sync)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_cnt = 1;
    m_speed = 0;
    m_blocked = 1'b0;
  endtask

  // One falling edge: predict, push, let DUT clock, pop and compare.
  task automatic step(input logic r, input logic [SW-1:0] sr,
                      input logic h);
    exp_t e;
    exp_t got;
    int   per;
    int   sel;
    @(posedge clock);
    run = r;
    speed_req = sr;
    hold = h;
    e = '0;
    e.spd = m_speed[SW-1:0];
    if (r) begin
      for (int k = 0; k < STAGES; k++) begin
        per = 4 << k;
        e.ne[k] = ((m_cnt % per) == 0);
        e.pe[k] = ((m_cnt % per) == per / 2);
      end
      sel = (m_speed > STAGES - 1) ? 0 : STAGES - 1 - m_speed;
      e.cpe = e.pe[sel];
      e.cne = e.ne[sel];
      if (e.cpe && h) begin
        e.cpe = 1'b0;
        m_blocked = 1'b1;
      end
      if (e.cne && m_blocked) begin
        e.cne = 1'b0;
        m_blocked = 1'b0;
      end
      if (e.ne[STAGES-1]) m_speed = int'(sr);
      e.spd = m_speed[SW-1:0];
      e.sync = e.ne[STAGES-1];
      m_cnt = (m_cnt + 1) % CMOD;
    end
    q.push_back(e);
    @(negedge clock);
    #1;
    e = q.pop_front();
    got = {pe, ne, cpu_pe, cpu_ne, speed, sync};
    n_total++;
    if (got !== e) begin
      $display("FAIL %s edge: got pe=%b ne=%b cpe=%b cne=%b spd=%0d sync=%b, need pe=%b ne=%b cpe=%b cne=%b spd=%0d sync=%b",
               tname, pe, ne, cpu_pe, cpu_ne, speed, sync,
               e.pe, e.ne, e.cpe, e.cne, e.spd, e.sync);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_reset();
    tname = "reset";
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({pe, ne, cpu_pe, cpu_ne, speed, sync} !== '0) begin
      $display("FAIL reset_outputs: got %b, need 0",
               {pe, ne, cpu_pe, cpu_ne, speed, sync});
    end else n_pass++;
    @(negedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int first_ne0 = -1;
    int ne0_last = -1;
    int ne0_per = -1;
    int ne2_last = -1;
    int ne2_per = -1;
    int pe2_gap = -1;
    int trk_err = 0;
    tname = "basic";
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 2'd0, 1'b0);
      if (ne[0]) begin
        if (first_ne0 < 0) first_ne0 = i;
        else if (ne0_per < 0) ne0_per = i - ne0_last;
        ne0_last = i;
      end
      if (ne[2]) begin
        if (ne2_last >= 0 && ne2_per < 0) ne2_per = i - ne2_last;
        ne2_last = i;
      end
      if (pe[2] && ne2_last >= 0 && pe2_gap < 0) pe2_gap = i - ne2_last;
      if (cpu_pe !== pe[2] || cpu_ne !== ne[2]) trk_err++;
    end
    n_total++;
    if (first_ne0 !== 4) $display("FAIL first_ne0: got edge %0d, need 4", first_ne0);
    else n_pass++;
    n_total++;
    if (ne0_per !== 4) $display("FAIL ne0_period: got %0d, need 4", ne0_per);
    else n_pass++;
    n_total++;
    if (ne2_per !== 16) $display("FAIL ne2_period: got %0d, need 16", ne2_per);
    else n_pass++;
    n_total++;
    if (pe2_gap !== 8) $display("FAIL pe2_gap: got %0d, need 8", pe2_gap);
    else n_pass++;
    n_total++;
    if (trk_err !== 0) $display("FAIL cpu_track: got %0d bad edges, need 0", trk_err);
    else n_pass++;
  endtask

  task automatic test_speed_change();
    bit seen = 0;
    int early = 0;
    int post = 0;
    int cpe_cnt = 0;
    tname = "speed_change";
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 2'd2, 1'b0);
      if (seen) begin
        if (post < 16 && cpu_pe) cpe_cnt++;
        post++;
      end else if (sync) begin
        seen = 1;
        n_total++;
        if (speed !== 2'd2) $display("FAIL speed_commit: got %0d, need 2", speed);
        else n_pass++;
      end else if (speed !== 2'd0) begin
        early++;
      end
    end
    n_total++;
    if (early !== 0 || !seen) $display("FAIL speed_early: got %0d early edges, seen=%0d, need 0 and 1", early, seen);
    else n_pass++;
    n_total++;
    if (cpe_cnt !== 4) $display("FAIL speed2_cpu_pe: got %0d, need 4", cpe_cnt);
    else n_pass++;
  endtask

  task automatic test_speed_clamp();
    int cne_cnt = 0;
    tname = "speed_clamp";
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 2'd3, 1'b0);
      if (i > 16 && cpu_ne) cne_cnt++;
    end
    n_total++;
    if (speed !== 2'd3) $display("FAIL clamp_speed: got %0d, need 3", speed);
    else n_pass++;
    n_total++;
    if (cne_cnt !== 4) $display("FAIL clamp_cpu_ne: got %0d, need 4", cne_cnt);
    else n_pass++;
  endtask

  task automatic test_hold();
    int guard = 0;
    int cpe_cnt = 0;
    int cne_cnt = 0;
    tname = "hold";
    while (!(m_speed == 1 && (m_cnt % 8) == 4) && guard < 40) begin
      step(1'b1, 2'd1, 1'b0);
      guard++;
    end
    n_total++;
    if (guard >= 40) $display("FAIL hold_setup: got timeout, need pe slot");
    else n_pass++;
    step(1'b1, 2'd1, 1'b1);
    n_total++;
    if (cpu_pe !== 1'b0 || pe[1] !== 1'b1) $display("FAIL hold_pe: got cpu_pe=%b pe1=%b, need 0 1", cpu_pe, pe[1]);
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 1'b0);
    n_total++;
    if (cpu_ne !== 1'b0 || ne[1] !== 1'b1) $display("FAIL hold_ne: got cpu_ne=%b ne1=%b, need 0 1", cpu_ne, ne[1]);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd1, 1'b0);
      if (cpu_pe) cpe_cnt++;
      if (cpu_ne) cne_cnt++;
    end
    n_total++;
    if (cpe_cnt !== 1 || cne_cnt !== 1) $display("FAIL hold_next_pair: got pe=%0d ne=%0d, need 1 1", cpe_cnt, cne_cnt);
    else n_pass++;
  endtask

  task automatic test_run_pause();
    int guard = 0;
    int zero_err = 0;
    int to_sync = -1;
    tname = "run_pause";
    while (m_cnt != 6 && guard < 20) begin
      step(1'b1, 2'd1, 1'b0);
      guard++;
    end
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 2'd1, 1'b0);
      if ({pe, ne, cpu_pe, cpu_ne, sync} !== '0) zero_err++;
    end
    n_total++;
    if (zero_err !== 0 || speed !== 2'd1) $display("FAIL pause_zero: got %0d bad edges speed=%0d, need 0 and 1", zero_err, speed);
    else n_pass++;
    for (int i = 6; i <= 30; i++) begin
      step(1'b1, 2'd1, 1'b0);
      if (sync && to_sync < 0) to_sync = i;
    end
    n_total++;
    if (to_sync !== 16) $display("FAIL pause_shift: got sync at %0d, need 16", to_sync);
    else n_pass++;
  endtask

  task automatic test_reset_blocked();
    int guard = 0;
    int first_cne = -1;
    tname = "reset_blocked";
    while (!(m_speed == 0 && m_cnt == 8) && guard < 40) begin
      step(1'b1, 2'd0, 1'b0);
      guard++;
    end
    step(1'b1, 2'd0, 1'b1);
    n_total++;
    if (cpu_pe !== 1'b0 || pe[2] !== 1'b1) $display("FAIL blk_pe: got cpu_pe=%b pe2=%b, need 0 1", cpu_pe, pe[2]);
    else n_pass++;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({pe, ne, cpu_pe, cpu_ne, speed, sync} !== '0) $display("FAIL blk_reset: got %b, need 0", {pe, ne, cpu_pe, cpu_ne, speed, sync});
    else n_pass++;
    @(negedge clock);
    #2;
    reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 2'd0, 1'b0);
      if (cpu_ne && first_cne < 0) first_cne = i;
    end
    n_total++;
    if (first_cne !== 16) $display("FAIL blk_first_cne: got edge %0d, need 16", first_cne);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_speed_change();
    test_speed_clamp();
    test_hold();
    test_run_pause();
    test_reset_blocked();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
